// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: funct3 encodings, FSM states and
// access-size/legality helpers used by the controller and the load extender.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        logic [3:0] size;
        case (funct3[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            default: size = 4'd8;
        endcase
        return size;
    endfunction

    function automatic logic funct3_legal(input logic [2:0] funct3, input logic we, input int data_w);
        logic legal;
        if (we) begin
            case (funct3)
                F3_SB, F3_SH, F3_SW: legal = 1'b1;
                F3_SD:               legal = (data_w == 64);
                default:             legal = 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: legal = 1'b1;
                F3_LD, F3_LWU:                       legal = (data_w == 64);
                default:                             legal = 1'b0;
            endcase
        end
        return legal;
    endfunction

endpackage

// File: rtl/mem_lsu_ctrl_if.sv
// Bundle of the pipeline request/response handshake and the aligned
// data-memory port of the load/store unit.
interface mem_lsu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_exc;
    logic                  stall;
    logic                  dm_req;
    logic                  dm_gnt;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W/8-1:0]   dm_wstrb;
    logic [DATA_W-1:0]     dm_wdata;
    logic                  dm_rvalid;
    logic [DATA_W-1:0]     dm_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc, stall,
        output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc, stall,
        input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata
    );
endinterface

// File: rtl/lsu_load_extend.sv
// Shifts the two-beat read window down by the byte offset, truncates it to
// the access size and sign- or zero-extends the result to DATA_W.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(NB)
) (
    input  logic [DATA_W-1:0] lo_word,
    input  logic [DATA_W-1:0] hi_word,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);
    logic [2*DATA_W-1:0] win_s;
    logic [3:0]          size_s;
    logic                sign_s;

    // Window shift, then per-byte select between loaded byte and extension.
    always_comb begin
        win_s  = {hi_word, lo_word} >> (8 * off);
        size_s = size_of(funct3);
        sign_s = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if (i == int'(size_s) - 1) begin
                sign_s = win_s[8*i+7] & ~funct3[2];
            end else begin
                sign_s = sign_s;
            end
        end
        data = '0;
        for (int i = 0; i < NB; i++) begin
            data[8*i +: 8] = (i < int'(size_s)) ? win_s[8*i +: 8] : {8{sign_s}};
        end
    end
endmodule

// File: rtl/mem_lsu_ctrl.sv
// Multi-cycle MEM-stage load/store unit: one access per handshake, aligned
// beats to data memory, optional two-beat split of misaligned accesses.
module mem_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mem_lsu_ctrl_if.slave bus
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e          state_r, next_state_s;
    logic                beat_r, split_r, we_r, exc_r, req_ready_r;
    logic [2:0]          funct3_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r, rbuf0_r, rbuf1_r;

    logic                accept_s, misaligned_s, exc_in_s, second_beat_s;
    logic [OFF_W-1:0]    off_s;
    logic [3:0]          size_s;
    logic [ADDR_W-1:0]   base_s, beat_addr_s;
    logic [2*DATA_W-1:0] wwin_s;
    logic [2*NB-1:0]     swin_s;
    logic [DATA_W-1:0]   load_data_s;

    // Request decode at the acceptance point.
    always_comb begin
        accept_s     = bus.req_valid & req_ready_r;
        misaligned_s = (int'(bus.req_addr[OFF_W-1:0]) + int'(size_of(bus.req_funct3))) > NB;
        exc_in_s     = ~funct3_legal(bus.req_funct3, bus.req_we, DATA_W)
                     | (misaligned_s & ~MISALIGN_SPLIT);
        second_beat_s = ~beat_r & split_r;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = exc_in_s ? RESP : ISSUE;
                else          next_state_s = IDLE;
            end
            ISSUE: begin
                if (bus.dm_gnt) begin
                    if (!we_r)              next_state_s = WAIT;
                    else if (second_beat_s) next_state_s = ISSUE;
                    else                    next_state_s = RESP;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            WAIT: begin
                if (bus.dm_rvalid) next_state_s = second_beat_s ? ISSUE : RESP;
                else               next_state_s = WAIT;
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, captured request fields and read-beat buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b0;
            beat_r      <= 1'b0;
            split_r     <= 1'b0;
            we_r        <= 1'b0;
            exc_r       <= 1'b0;
            funct3_r    <= 3'b000;
            addr_r      <= '0;
            wdata_r     <= '0;
            rbuf0_r     <= '0;
            rbuf1_r     <= '0;
        end else begin
            state_r     <= next_state_s;
            req_ready_r <= (next_state_s == IDLE);
            if (accept_s) begin
                beat_r   <= 1'b0;
                split_r  <= misaligned_s;
                we_r     <= bus.req_we;
                exc_r    <= exc_in_s;
                funct3_r <= bus.req_funct3;
                addr_r   <= bus.req_addr;
                wdata_r  <= bus.req_wdata;
                rbuf0_r  <= '0;
                rbuf1_r  <= '0;
            end else if (state_r == ISSUE && bus.dm_gnt && we_r && second_beat_s) begin
                beat_r <= 1'b1;
            end else if (state_r == WAIT && bus.dm_rvalid) begin
                if (beat_r) rbuf1_r <= bus.dm_rdata;
                else        rbuf0_r <= bus.dm_rdata;
                beat_r <= beat_r | split_r;
            end
        end
    end

    // Beat address and store byte-lane placement across the two-beat window.
    always_comb begin
        off_s       = addr_r[OFF_W-1:0];
        size_s      = size_of(funct3_r);
        base_s      = {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        beat_addr_s = beat_r ? base_s + ADDR_W'(NB) : base_s;
        wwin_s      = {{DATA_W{1'b0}}, wdata_r} << (8 * off_s);
        for (int i = 0; i < 2*NB; i++) begin
            swin_s[i]        = (i >= int'(off_s)) && (i < int'(off_s) + int'(size_s));
            wwin_s[8*i +: 8] = swin_s[i] ? wwin_s[8*i +: 8] : 8'h00;
        end
    end

    lsu_load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .lo_word (rbuf0_r),
        .hi_word (rbuf1_r),
        .off     (off_s),
        .funct3  (funct3_r),
        .data    (load_data_s)
    );

    // Output decode from registered state.
    always_comb begin
        bus.req_ready = req_ready_r;
        bus.stall     = (state_r != IDLE);
        bus.rsp_valid = (state_r == RESP);
        bus.rsp_exc   = (state_r == RESP) & exc_r;
        bus.rsp_rdata = ((state_r == RESP) && !we_r && !exc_r) ? load_data_s : '0;
        bus.dm_req    = (state_r == ISSUE);
        bus.dm_we     = (state_r == ISSUE) & we_r;
        bus.dm_addr   = (state_r == ISSUE) ? beat_addr_s : '0;
        if (state_r == ISSUE && we_r) begin
            bus.dm_wstrb = beat_r ? swin_s[2*NB-1:NB] : swin_s[NB-1:0];
            bus.dm_wdata = beat_r ? wwin_s[2*DATA_W-1:DATA_W] : wwin_s[DATA_W-1:0];
        end else begin
            bus.dm_wstrb = '0;
            bus.dm_wdata = '0;
        end
    end
endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl: split and non-split instances driven from
// vector tables, plus a hand-written abort-by-reset sequence.
module tb_mem_lsu_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          gnt_dly;
        int          nbeats;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] rdata;
        logic        exc;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, dm_gnt = 1'b0, dm_rvalid = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, dm_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    mem_lsu_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_a ();
    mem_lsu_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus_b ();

    mem_lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    assign bus_a.req_valid  = req_valid & ~sel;
    assign bus_b.req_valid  = req_valid & sel;
    assign bus_a.req_we     = req_we;
    assign bus_b.req_we     = req_we;
    assign bus_a.req_funct3 = req_funct3;
    assign bus_b.req_funct3 = req_funct3;
    assign bus_a.req_addr   = req_addr;
    assign bus_b.req_addr   = req_addr;
    assign bus_a.req_wdata  = req_wdata;
    assign bus_b.req_wdata  = req_wdata;
    assign bus_a.dm_gnt     = dm_gnt & ~sel;
    assign bus_b.dm_gnt     = dm_gnt & sel;
    assign bus_a.dm_rvalid  = dm_rvalid & ~sel;
    assign bus_b.dm_rvalid  = dm_rvalid & sel;
    assign bus_a.dm_rdata   = dm_rdata;
    assign bus_b.dm_rdata   = dm_rdata;

    wire        cur_ready  = sel ? bus_b.req_ready : bus_a.req_ready;
    wire        cur_rvld   = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    wire [31:0] cur_rdata  = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    wire        cur_exc    = sel ? bus_b.rsp_exc   : bus_a.rsp_exc;
    wire        cur_stall  = sel ? bus_b.stall     : bus_a.stall;
    wire        cur_dmreq  = sel ? bus_b.dm_req    : bus_a.dm_req;
    wire        cur_dmwe   = sel ? bus_b.dm_we     : bus_a.dm_we;
    wire [31:0] cur_dmaddr = sel ? bus_b.dm_addr   : bus_a.dm_addr;
    wire [3:0]  cur_wstrb  = sel ? bus_b.dm_wstrb  : bus_a.dm_wstrb;
    wire [31:0] cur_wdata  = sel ? bus_b.dm_wdata  : bus_a.dm_wdata;

    vec_t va[16];
    vec_t vb[5];
    vec_t v_after;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One access: inputs driven and outputs sampled on the falling edge.
    task automatic run_vec(input vec_t v, input string nm);
        int   cyc, beat, dly;
        logic pend, done;
        logic [31:0] pend_data;
        @(negedge clk);
        chk({nm, " ready"}, {31'd0, cur_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1; beat = 0; dly = 0; pend = 1'b0; done = 1'b0; pend_data = 32'h0;
        while (!done && cyc < 40) begin
            dm_rvalid = pend;
            dm_rdata  = pend ? pend_data : 32'h0;
            pend      = 1'b0;
            dm_gnt    = 1'b0;
            if (cur_rvld) begin
                chk({nm, " rdata"}, cur_rdata, v.rdata);
                chk({nm, " exc"}, {31'd0, cur_exc}, {31'd0, v.exc});
                chk({nm, " latency"}, cyc, v.lat);
                chk({nm, " beats"}, beat, v.nbeats);
                done = 1'b1;
            end else begin
                chk({nm, " stall"}, {31'd0, cur_stall}, 32'd1);
                if (cur_dmreq) begin
                    if (beat >= v.nbeats) begin
                        chk({nm, " extra beat"}, beat, v.nbeats);
                    end else begin
                        chk($sformatf("%s b%0d addr", nm, beat), cur_dmaddr, beat == 0 ? v.a0 : v.a1);
                        chk($sformatf("%s b%0d we", nm, beat), {31'd0, cur_dmwe}, {31'd0, v.we});
                        if (v.we) begin
                            chk($sformatf("%s b%0d wstrb", nm, beat), {28'd0, cur_wstrb}, {28'd0, beat == 0 ? v.s0 : v.s1});
                            chk($sformatf("%s b%0d wdata", nm, beat), cur_wdata, beat == 0 ? v.w0 : v.w1);
                        end
                    end
                    if (beat == 0 && dly < v.gnt_dly) begin
                        dly++;
                    end else begin
                        dm_gnt = 1'b1;
                        if (!v.we) begin
                            pend      = 1'b1;
                            pend_data = (beat == 0) ? v.rd0 : v.rd1;
                        end
                        beat++;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) chk({nm, " timeout"}, 32'd0, 32'd1);
        dm_gnt = 1'b0;
        dm_rvalid = 1'b0;
    endtask

    initial begin
        //            we    f3      addr          wdata         rd0           rd1         dly nb a0            a1            s0       s1       w0            w1            rdata         exc  lat
        va[0]  = '{1'b1, F3_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b1111, 4'b0000, 32'hDEAD_BEEF, 32'h0,        32'h0,        1'b0, 2};
        va[1]  = '{1'b0, F3_LB,  32'h0000_0103, 32'h0,        32'h80FF_0000, 32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'hFFFF_FF80, 1'b0, 3};
        va[2]  = '{1'b0, F3_LBU, 32'h0000_0103, 32'h0,        32'h80FF_0000, 32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0000_0080, 1'b0, 3};
        va[3]  = '{1'b0, F3_LW,  32'h0000_0102, 32'h0,        32'h1122_3344, 32'h5566_7788, 0, 2, 32'h0000_0100, 32'h0000_0104, 4'b0000, 4'b0000, 32'h0,        32'h0,        32'h7788_1122, 1'b0, 5};
        va[4]  = '{1'b1, F3_SH,  32'h0000_0103, 32'h0000_ABCD, 32'h0,        32'h0,        3, 2, 32'h0000_0100, 32'h0000_0104, 4'b1000, 4'b0001, 32'hCD00_0000, 32'h0000_00AB, 32'h0,        1'b0, 6};
        va[5]  = '{1'b0, F3_LH,  32'h0000_0102, 32'h0,        32'h8001_0000, 32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'hFFFF_8001, 1'b0, 3};
        va[6]  = '{1'b0, F3_LHU, 32'h0000_0100, 32'h0,        32'h1234_8765, 32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0000_8765, 1'b0, 3};
        va[7]  = '{1'b1, F3_SB,  32'h0000_0101, 32'h1234_56AA, 32'h0,        32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b0010, 4'b0000, 32'h0000_AA00, 32'h0,        32'h0,        1'b0, 2};
        va[8]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        va[9]  = '{1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        va[10] = '{1'b0, 3'b111, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        va[11] = '{1'b0, F3_LW,  32'hFFFF_FFFE, 32'h0,        32'hAABB_CCDD, 32'h1122_3344, 0, 2, 32'hFFFF_FFFC, 32'h0000_0000, 4'b0000, 4'b0000, 32'h0,        32'h0,        32'h3344_AABB, 1'b0, 5};
        va[12] = '{1'b1, F3_SW,  32'h0000_0101, 32'h1122_3344, 32'h0,        32'h0,        0, 2, 32'h0000_0100, 32'h0000_0104, 4'b1110, 4'b0001, 32'h2233_4400, 32'h0000_0011, 32'h0,        1'b0, 3};
        va[13] = '{1'b0, F3_LB,  32'h0000_0100, 32'h0,        32'h0000_007F, 32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0000_007F, 1'b0, 3};
        va[14] = '{1'b0, F3_LW,  32'h0000_0104, 32'h0,        32'hCAFE_BABE, 32'h0,        0, 1, 32'h0000_0104, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'hCAFE_BABE, 1'b0, 3};
        va[15] = '{1'b0, F3_LHU, 32'h0000_0103, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 0, 2, 32'h0000_0100, 32'h0000_0104, 4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0000_CDAB, 1'b0, 5};
        v_after = '{1'b0, F3_LW, 32'h0000_0200, 32'h0,        32'h0BAD_F00D, 32'h0,        0, 1, 32'h0000_0200, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0BAD_F00D, 1'b0, 3};
        vb[0]  = '{1'b0, F3_LW,  32'h0000_0101, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        vb[1]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        vb[2]  = '{1'b1, F3_SH,  32'h0000_0103, 32'h0000_ABCD, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        vb[3]  = '{1'b0, F3_LW,  32'h0000_0100, 32'h0,        32'h1234_5678, 32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h1234_5678, 1'b0, 3};
        vb[4]  = '{1'b0, F3_LH,  32'h0000_0102, 32'h0,        32'h7FFF_0000, 32'h0,        0, 1, 32'h0000_0100, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0000_7FFF, 1'b0, 3};

        // Reset state: ready held low during reset, all other outputs low.
        repeat (2) @(negedge clk);
        chk("rst ready", {31'd0, cur_ready}, 32'd0);
        chk("rst stall", {31'd0, cur_stall}, 32'd0);
        chk("rst dm_req", {31'd0, cur_dmreq}, 32'd0);
        chk("rst rsp_valid", {31'd0, cur_rvld}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst ready", {31'd0, cur_ready}, 32'd1);
        chk("post-rst dm_addr", cur_dmaddr, 32'd0);

        for (int i = 0; i < 16; i++) run_vec(va[i], $sformatf("A%0d", i));

        // Abort a load in WAIT with reset; the late rvalid must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_LW; req_addr = 32'h0000_0100;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort dm_req", {31'd0, cur_dmreq}, 32'd1);
        dm_gnt = 1'b1;
        @(negedge clk);
        dm_gnt = 1'b0;
        chk("abort wait stall", {31'd0, cur_stall}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort dm_req low", {31'd0, cur_dmreq}, 32'd0);
        chk("abort stall low", {31'd0, cur_stall}, 32'd0);
        chk("abort no rsp", {31'd0, cur_rvld}, 32'd0);
        @(negedge clk);
        chk("abort ready", {31'd0, cur_ready}, 32'd1);
        dm_rvalid = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dm_rvalid = 1'b0;
            chk($sformatf("late rvalid no rsp %0d", i), {31'd0, cur_rvld}, 32'd0);
        end
        run_vec(v_after, "after-abort LW");

        sel = 1'b1;
        for (int i = 0; i < 5; i++) run_vec(vb[i], $sformatf("B%0d", i));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_lsu_ctrl.md
Name: mem_lsu_ctrl

Overview:
Parametrised multi-cycle load/store unit for the MEM stage. It replaces the single-cycle combinational store replication and load extension used so far.
- Accepts one load/store per request handshake.
- Drives an aligned request/grant/rvalid port to the data memory (SRAM or DRAM wrapper).
- Splits misaligned accesses into two aligned beats, or flags them as exceptions.
- Returns a sign/zero-extended load result.
- Asserts a stall to the pipeline while busy.

Parameters:
- DATA_W, 32, memory/data width in bits; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- MISALIGN_SPLIT, 1, 1 = split misaligned accesses into two beats; 0 = raise rsp_exc and issue no memory access.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  DATA_W  store data (rs2), LSB-justified
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and exceptions
- rsp_exc  out  1  valid with rsp_valid: misaligned (MISALIGN_SPLIT=0) or illegal funct3
- stall  out  1  high whenever state != IDLE
- dm_req  out  1  memory request
- dm_gnt  in  1  memory accepts the request this cycle
- dm_we  out  1  write beat
- dm_addr  out  ADDR_W  aligned beat address (low log2(DATA_W/8) bits zero)
- dm_wstrb  out  DATA_W/8  active-high byte strobes
- dm_wdata  out  DATA_W  beat write data
- dm_rvalid  in  1  read data valid; memory guarantees at least 1 cycle after dm_gnt
- dm_rdata  in  DATA_W  read data

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE and the beat buffers clear. All outputs are 0 except req_ready=1, which appears the cycle after rst deasserts.
- Accept: a request is accepted when req_valid && req_ready are both high in a cycle. The unit registers we, funct3, addr, wdata and computes:
  - off = addr[log2(NB)-1:0], where NB = DATA_W/8.
  - size = 1, 2, 4 or 8 bytes.
  - misaligned when off+size > NB; nbeats = 2 in that case, otherwise 1.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101. 011 and 110 are legal only when DATA_W=64.
  - Stores: 000, 001, 010. 011 is legal only when DATA_W=64.
  - Any other value produces rsp_exc.
- States:
  - IDLE → ISSUE on accept.
  - IDLE → RESP with exc=1 on accept if funct3 is illegal, or if misaligned and MISALIGN_SPLIT=0.
  - ISSUE: dm_req=1 with stable addr/we/wstrb/wdata until dm_gnt. On gnt: load → WAIT; store → ISSUE again (beat=1) if beat=0 and nbeats=2, otherwise → RESP.
  - WAIT: on dm_rvalid, capture dm_rdata into buf[beat]. Then → ISSUE (beat=1) if beat=0 and nbeats=2, otherwise → RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then → IDLE.
- Beat addresses: beat0 = addr with the low bits cleared; beat1 = beat0 + NB (wraps modulo 2^ADDR_W).
- Store data: the 2*DATA_W window is (wdata zero-extended) << 8*off, and the strobe window is ((1<<size)-1) << off. Beat0 takes the low halves, beat1 the high halves. Bytes with strobe 0 are driven to 0.
- Load data: ({buf1, buf0} >> 8*off) is truncated to size bytes, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to DATA_W.
- Latency with dm_gnt immediate and dm_rvalid one cycle after gnt, where C = accept cycle:
  - Aligned store: rsp_valid at C+2.
  - Aligned load: rsp_valid at C+3.
  - Split store: rsp_valid at C+3.
  - Split load: rsp_valid at C+5.
  - Exception: rsp_valid at C+1, with no dm_req.
- dm_rvalid outside WAIT is ignored.
- req_valid while busy is not accepted; the pipeline holds via stall.
- rst in any state aborts immediately: dm_req drops next cycle and no rsp_valid is produced. A late dm_rvalid from the aborted access is ignored.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants (LB..LWU, SB..SD).
  - State enum typedef: IDLE, ISSUE, WAIT, RESP.
  - Function size_of(funct3).
  - Function funct3_legal(funct3, we, DATA_W).
- Sub-module lsu_load_extend: combinational shift/truncate/extend of the {buf1, buf0} window. It is reused by the forthcoming cache path.

Test Plan:
All tests use DATA_W=32 unless stated.
1. SW addr 0x100, wdata 0xDEADBEEF, dm_gnt immediate → one beat: dm_addr 0x100, wstrb 1111, wdata 0xDEADBEEF; rsp_valid at C+2, rsp_exc 0.
2. LB addr 0x103, dm_rdata 0x80FF0000 → rsp_rdata 0xFFFFFF80. Repeat as LBU → 0x00000080. Each has a single beat at 0x100.
3. LW addr 0x102, MISALIGN_SPLIT=1, beat0 returns 0x11223344, beat1 returns 0x55667788 → beats at 0x100 then 0x104; rsp_rdata 0x77881122 at C+5.
4. SH addr 0x103, wdata 0x0000ABCD → beat0: addr 0x100, wstrb 1000, wdata 0xCD000000. Beat1: addr 0x104, wstrb 0001, wdata 0x000000AB. dm_gnt delayed 3 cycles on beat0 with request fields held stable throughout.
5. MISALIGN_SPLIT=0, LW addr 0x101 → no dm_req; rsp_valid at C+1 with rsp_exc=1 and rsp_rdata 0. Also funct3=011 at DATA_W=32 → rsp_exc=1.
6. rst pulsed while in WAIT → next cycle dm_req=0, stall=0, req_ready=1; a subsequent dm_rvalid produces no rsp_valid. A following LW at 0x200 completes normally.
